// File: rtl/cards_pkg.sv
// Shared definitions for the card-game datapath: deck geometry, LFSR constants
// and the shuffler state encoding.
package cards_pkg;

    localparam int          DECK_SIZE    = 52;
    localparam int          CARD_W       = 6;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SHUFFLE,
        READY
    } deck_state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with loadable seed; a zero load value falls back to SEED
// so the register can never lock up at all-zeros.
module lfsr16 #(
    parameter logic [15:0] SEED = cards_pkg::DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic [15:0] q
);
    import cards_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= (load_val == 16'h0000) ? SEED : load_val;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// Builds an identity deck, Fisher-Yates shuffles it with an LFSR (one swap per
// cycle) and then deals one card per draw request.
module deck_shuffler #(
    parameter int          SIZE         = cards_pkg::DECK_SIZE,
    parameter int          CW           = cards_pkg::CARD_W,
    parameter logic [15:0] DEFAULT_SEED = cards_pkg::DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          seed_we,
    input  logic [15:0]   seed_in,
    input  logic          start,
    input  logic          draw_req,
    output logic [CW-1:0] card_out,
    output logic          card_valid,
    output logic          draw_err,
    output logic          busy,
    output logic          shuffle_done,
    output logic [CW:0]   cards_left
);
    import cards_pkg::*;

    localparam logic [CW:0]   SIZE_W = (CW+1)'(SIZE);
    localparam logic [CW-1:0] LAST   = CW'(SIZE - 1);

    deck_state_t     state_reg;
    logic            start_pend_reg;
    logic [CW-1:0]   idx_reg;
    logic [CW:0]     ptr_reg;
    logic [CW-1:0]   deck [SIZE];
    logic [15:0]     lfsr_q;
    logic [16+CW:0]  prod;
    logic [CW-1:0]   j;
    logic            cfg_ok;
    logic            deal_ok;

    // Seeding is only legal while the deck is not being rebuilt, including the
    // one-cycle gap between an accepted start and the first INIT cycle.
    assign cfg_ok  = (state_reg == IDLE || state_reg == READY) && !start_pend_reg;
    assign deal_ok = draw_req && (state_reg == READY) && !start && (cards_left != '0);

    lfsr16 #(.SEED(DEFAULT_SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_we && cfg_ok),
        .load_val (seed_in),
        .en       (state_reg == SHUFFLE),
        .q        (lfsr_q)
    );

    // j = (lfsr * (i+1)) >> 16, kept full width so j never exceeds i.
    always_comb begin
        prod = {{(CW+1){1'b0}}, lfsr_q} * {16'h0000, ({1'b0, idx_reg} + 1'b1)};
        j    = CW'(prod >> 16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            start_pend_reg <= 1'b0;
            idx_reg        <= '0;
            ptr_reg        <= '0;
            card_out       <= '0;
            card_valid     <= 1'b0;
            draw_err       <= 1'b0;
            busy           <= 1'b0;
            shuffle_done   <= 1'b0;
            cards_left     <= '0;
        end else begin
            card_valid     <= 1'b0;
            shuffle_done   <= 1'b0;
            draw_err       <= draw_req && !deal_ok;
            start_pend_reg <= 1'b0;
            case (state_reg)
                IDLE, READY: begin
                    if (start_pend_reg) begin
                        state_reg <= INIT;
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                    end else if (start) begin
                        start_pend_reg <= 1'b1;
                        state_reg      <= IDLE;
                        ptr_reg        <= '0;
                        cards_left     <= '0;
                    end else if (deal_ok) begin
                        card_out   <= deck[ptr_reg[CW-1:0]];
                        card_valid <= 1'b1;
                        ptr_reg    <= ptr_reg + 1'b1;
                        cards_left <= cards_left - 1'b1;
                    end
                end
                INIT: begin
                    if (idx_reg == LAST) begin
                        state_reg <= SHUFFLE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                SHUFFLE: begin
                    if (idx_reg == CW'(1)) begin
                        state_reg    <= READY;
                        busy         <= 1'b0;
                        shuffle_done <= 1'b1;
                        cards_left   <= SIZE_W;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Deck needs two reads and two writes per swap, so it stays in registers.
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            deck[idx_reg] <= idx_reg;
        end else if (state_reg == SHUFFLE) begin
            deck[idx_reg] <= deck[j];
            deck[j]       <= deck[idx_reg];
        end
    end

endmodule
